// File: rtl/cci_status_writer.sv
// Status-line producer for the CCI write arbiter: keeps AFU progress counters and posts a
// snapshot to one host line, periodically or on error, with a single write in flight.
module cci_status_writer #(
  parameter int unsigned MDATA_W    = 14,
  parameter logic [1:0]  STATUS_TAG = 2'b11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               afu_en,
  input  logic [31:0]        status_base_addr,
  input  logic [15:0]        update_period,
  input  logic               frame_written_inc,
  input  logic               frame_read_inc,
  input  logic               error_pulse,
  input  logic [7:0]         error_code,
  output logic               write_request,
  output logic [31:0]        write_addr,
  output logic [MDATA_W-1:0] write_mdata,
  output logic [511:0]       write_data,
  input  logic               write_grant,
  input  logic               write_resp_valid,
  input  logic [MDATA_W-1:0] write_resp_mdata,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitResp} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fw_cnt_q, fw_cnt_d, fr_cnt_q, fr_cnt_d, seq_q, seq_d;
  logic [7:0]         err_code_q, err_code_d;
  logic               err_sticky_q, err_sticky_d;
  logic [15:0]        timer_q, timer_d;
  logic               pending_q, pending_d;
  logic [31:0]        addr_q, addr_d;
  logic [MDATA_W-1:0] mdata_q, mdata_d;
  logic [31:0]        snap_fw_q, snap_fw_d, snap_fr_q, snap_fr_d, snap_seq_q, snap_seq_d;
  logic [7:0]         snap_code_q, snap_code_d;
  logic               snap_sticky_q, snap_sticky_d;
  logic               timer_hit, trigger;

  // A zero period parks the timer at zero so the first nonzero period starts a full count.
  assign timer_hit = (update_period != 16'd0) && (timer_q == 16'd1);
  assign timer_d   = ((update_period == 16'd0) || (timer_q <= 16'd1)) ? update_period
                                                                        : timer_q - 16'd1;
  assign trigger   = timer_hit || error_pulse;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    seq_d         = seq_q;
    addr_d        = addr_q;
    mdata_d       = mdata_q;
    snap_fw_d     = snap_fw_q;
    snap_fr_d     = snap_fr_q;
    snap_seq_d    = snap_seq_q;
    snap_code_d   = snap_code_q;
    snap_sticky_d = snap_sticky_q;
    fw_cnt_d      = fw_cnt_q + {31'd0, frame_written_inc};
    fr_cnt_d      = fr_cnt_q + {31'd0, frame_read_inc};
    err_code_d    = err_code_q;
    err_sticky_d  = err_sticky_q;
    if (error_pulse) begin
      err_code_d   = error_code;
      err_sticky_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        pending_d = trigger;
        if (pending_q) begin
          // Snapshot uses register values, i.e. before this cycle's increments.
          snap_fw_d     = fw_cnt_q;
          snap_fr_d     = fr_cnt_q;
          snap_seq_d    = seq_q;
          snap_code_d   = err_code_q;
          snap_sticky_d = err_sticky_q;
          addr_d        = status_base_addr;
          mdata_d       = {STATUS_TAG, seq_q[MDATA_W-3:0]};
          state_d       = StReq;
        end
      end
      StReq: begin
        pending_d = pending_q | trigger;
        if (write_grant) begin
          seq_d   = seq_q + 32'd1;
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        pending_d = pending_q | trigger;
        if (write_resp_valid && (write_resp_mdata == mdata_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !afu_en) begin
      state_q       <= StIdle;
      fw_cnt_q      <= '0;
      fr_cnt_q      <= '0;
      seq_q         <= '0;
      err_code_q    <= '0;
      err_sticky_q  <= 1'b0;
      timer_q       <= update_period;
      pending_q     <= 1'b0;
      addr_q        <= '0;
      mdata_q       <= '0;
      snap_fw_q     <= '0;
      snap_fr_q     <= '0;
      snap_seq_q    <= '0;
      snap_code_q   <= '0;
      snap_sticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fw_cnt_q      <= fw_cnt_d;
      fr_cnt_q      <= fr_cnt_d;
      seq_q         <= seq_d;
      err_code_q    <= err_code_d;
      err_sticky_q  <= err_sticky_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      addr_q        <= addr_d;
      mdata_q       <= mdata_d;
      snap_fw_q     <= snap_fw_d;
      snap_fr_q     <= snap_fr_d;
      snap_seq_q    <= snap_seq_d;
      snap_code_q   <= snap_code_d;
      snap_sticky_q <= snap_sticky_d;
    end
  end

  assign write_request = (state_q == StReq);
  assign busy          = (state_q != StIdle);
  assign write_addr    = addr_q;
  assign write_mdata   = mdata_q;
  assign write_data    = {384'd0, snap_seq_q, 23'd0, snap_sticky_q, snap_code_q,
                          snap_fr_q, snap_fw_q};

endmodule

// File: tb/tb_cci_status_writer.sv
// Randomised and directed bench for cci_status_writer against a cycle-level behavioural model,
// with an auto-responding arbiter/rx stub.
module tb_cci_status_writer;

  logic         clk = 1'b0;
  logic         reset, afu_en;
  logic [31:0]  status_base_addr;
  logic [15:0]  update_period;
  logic         frame_written_inc, frame_read_inc, error_pulse;
  logic [7:0]   error_code;
  logic         write_request, busy;
  logic [31:0]  write_addr;
  logic [13:0]  write_mdata;
  logic [511:0] write_data;
  logic         write_grant, write_resp_valid;
  logic [13:0]  write_resp_mdata;

  always #5 clk = ~clk;

  cci_status_writer #(.MDATA_W(14), .STATUS_TAG(2'b11)) dut (
    .clk              (clk),
    .reset            (reset),
    .afu_en           (afu_en),
    .status_base_addr (status_base_addr),
    .update_period    (update_period),
    .frame_written_inc(frame_written_inc),
    .frame_read_inc   (frame_read_inc),
    .error_pulse      (error_pulse),
    .error_code       (error_code),
    .write_request    (write_request),
    .write_addr       (write_addr),
    .write_mdata      (write_mdata),
    .write_data       (write_data),
    .write_grant      (write_grant),
    .write_resp_valid (write_resp_valid),
    .write_resp_mdata (write_resp_mdata),
    .busy             (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] fw, input logic [31:0] fr,
                                           input logic [7:0] code, input logic sticky,
                                           input logic [31:0] seq);
    logic [511:0] l;
    l          = '0;
    l[31:0]    = fw;
    l[63:32]   = fr;
    l[71:64]   = code;
    l[72]      = sticky;
    l[127:96]  = seq;
    return l;
  endfunction

  // Arbiter / rx stub
  logic       grant_en = 1'b1, gnt_rand = 1'b1, resp_auto = 1'b1, noise_en = 1'b0;
  int         grant_pct = 100;
  logic       auto_v = 1'b0, man_valid = 1'b0;
  logic [13:0] auto_tag = '0, man_tag = '0, xfer_tag = '0;
  logic       xfer_q = 1'b0;
  int         resp_cnt = 0;

  assign write_grant      = grant_en && write_request && gnt_rand;
  assign write_resp_valid = resp_auto ? auto_v : man_valid;
  assign write_resp_mdata = resp_auto ? auto_tag : man_tag;

  always @(posedge clk) begin
    xfer_q   = write_request && write_grant;
    xfer_tag = write_mdata;
  end

  always @(negedge clk) begin
    auto_v = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        auto_v   = 1'b1;
        auto_tag = xfer_tag;
      end
    end else if (noise_en && $urandom_range(0, 9) == 0) begin
      auto_v   = 1'b1;
      auto_tag = 14'($urandom);
    end
    if (xfer_q && resp_auto) resp_cnt = 3;
    gnt_rand = ($urandom_range(0, 99) < grant_pct);
  end

  // Behavioural model: timer phase counts cycles since the last (re)load.
  logic [31:0]  m_fw = '0, m_fr = '0, m_seq = '0;
  logic [7:0]   m_code = '0;
  logic         m_sticky = 1'b0, m_pend = 1'b0, m_req = 1'b0, m_wait = 1'b0;
  int           m_ph = 0;
  logic [31:0]  e_addr = '0;
  logic [13:0]  e_mdata = '0;
  logic [511:0] e_data = '0;
  logic         force_fw = 1'b0;

  always @(posedge clk) begin
    bit tk, trig;
    if (reset || !afu_en) begin
      m_fw = '0; m_fr = '0; m_seq = '0; m_code = '0; m_sticky = 1'b0;
      m_pend = 1'b0; m_req = 1'b0; m_wait = 1'b0; m_ph = 0;
      e_addr = '0; e_mdata = '0; e_data = '0;
    end else begin
      tk   = (update_period != 0) && (m_ph == int'(update_period) - 1);
      m_ph = (update_period == 0 || tk) ? 0 : m_ph + 1;
      trig = tk || error_pulse;
      if (force_fw) m_fw = 32'hFFFF_FFFF;
      if (m_req) begin
        m_pend = m_pend | trig;
        if (write_grant) begin
          m_req = 1'b0; m_wait = 1'b1; m_seq = m_seq + 1;
        end
      end else if (m_wait) begin
        m_pend = m_pend | trig;
        if (write_resp_valid && write_resp_mdata == e_mdata) m_wait = 1'b0;
      end else if (m_pend) begin
        e_data  = mk_line(m_fw, m_fr, m_code, m_sticky, m_seq);
        e_addr  = status_base_addr;
        e_mdata = {2'b11, m_seq[11:0]};
        m_req   = 1'b1;
        m_pend  = trig;
      end else begin
        m_pend = trig;
      end
      m_fw = m_fw + 32'(frame_written_inc);
      m_fr = m_fr + 32'(frame_read_inc);
      if (error_pulse) begin
        m_code = error_code; m_sticky = 1'b1;
      end
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_req",   write_request, m_req);
      chk("cyc_busy",  busy, m_req | m_wait);
      chk("cyc_addr",  write_addr, e_addr);
      chk("cyc_mdata", write_mdata, e_mdata);
      chk("cyc_data",  write_data, e_data);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic err(input logic [7:0] c);
    error_pulse = 1'b1; error_code = c;
    tick(1);
    error_pulse = 1'b0;
  endtask

  task automatic wait_req(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (write_request) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("FAIL %s: no write_request within %0d cycles (got 0, expected 1)", name, max);
  endtask

  initial begin
    int cnt, t0, t1, t2;
    logic [13:0]  tag;
    logic [511:0] cap;
    logic         prev;

    reset = 1'b1; afu_en = 1'b1; status_base_addr = 32'h1234_5600; update_period = 16'd0;
    frame_written_inc = 1'b0; frame_read_inc = 1'b0; error_pulse = 1'b0; error_code = 8'h00;
    tick(3);
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst_req", write_request, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", write_data, '0);
    chk("rst_mdata", write_mdata, 14'h0);

    // Idle with periodic writes disabled
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (write_request || busy) cnt++;
    end
    chk("idle_no_req", cnt, 0);
    chk("idle_data", write_data, '0);

    // Periodic writes every 10 cycles
    afu_en = 1'b0; update_period = 16'd10;
    tick(1);
    afu_en = 1'b1;
    wait_req("per_0", 30); t0 = cyc;
    chk("per_seq0", write_data[127:96], 32'd0);
    chk("per_mdata0", write_mdata, 14'h3000);
    chk("per_addr0", write_addr, 32'h1234_5600);
    tick(1);
    wait_req("per_1", 30); t1 = cyc;
    chk("per_seq1", write_data[127:96], 32'd1);
    chk("per_mdata1", write_mdata, 14'h3001);
    tick(1);
    wait_req("per_2", 30); t2 = cyc;
    chk("per_seq2", write_data[127:96], 32'd2);
    chk("per_gap01", t1 - t0, 10);
    chk("per_gap12", t2 - t1, 10);

    // Counter pulses then an error
    afu_en = 1'b0; update_period = 16'd0;
    tick(1);
    afu_en = 1'b1;
    frame_written_inc = 1'b1;                       tick(3);
    frame_read_inc = 1'b1;                          tick(2);
    frame_written_inc = 1'b0;                       tick(1);
    frame_read_inc = 1'b0;
    err(8'h5A);
    wait_req("err_req", 10);
    chk("err_line", write_data, mk_line(32'd5, 32'd3, 8'h5A, 1'b1, 32'd0));
    tick(10);

    // Grant withheld while counters move
    grant_en = 1'b0;
    err(8'h11);
    wait_req("hold_req", 10);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      frame_written_inc = 1'b1;
      tick(1);
      if (write_request) cnt++;
    end
    frame_written_inc = 1'b0;
    chk("hold_req_cycles", cnt, 20);
    chk("hold_line", write_data, mk_line(32'd5, 32'd3, 8'h11, 1'b1, 32'd1));
    grant_en = 1'b1;
    tick(6);
    err(8'h22);
    wait_req("after_hold_req", 20);
    chk("after_hold_line", write_data, mk_line(32'd25, 32'd3, 8'h22, 1'b1, 32'd2));
    tick(10);

    // Wrong-tag response and coalesced errors in WAIT_RESP
    resp_auto = 1'b0;
    tick(2);
    err(8'h33);
    wait_req("wr_req", 10);
    tag = write_mdata;
    tick(1);
    man_valid = 1'b1; man_tag = tag ^ 14'h1;
    tick(1);
    man_valid = 1'b0;
    chk("wr_busy_wrongtag", busy, 1'b1);
    err(8'h44);
    err(8'h55);
    tick(2);
    chk("wr_busy_still", busy, 1'b1);
    man_valid = 1'b1; man_tag = tag;
    tick(1);
    man_valid = 1'b0; resp_auto = 1'b1;
    cnt = 0; prev = 1'b0; cap = '0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (write_request && !prev) begin
        cnt++; cap = write_data;
      end
      prev = write_request;
    end
    chk("wr_one_write", cnt, 1);
    chk("wr_line", cap, mk_line(32'd25, 32'd3, 8'h55, 1'b1, 32'd4));

    // Counter wrap
    force dut.fw_cnt_q = 32'hFFFF_FFFF;
    force_fw = 1'b1;
    tick(1);
    release dut.fw_cnt_q;
    force_fw = 1'b0;
    frame_written_inc = 1'b1;
    tick(1);
    frame_written_inc = 1'b0;
    err(8'h66);
    wait_req("wrap_req", 10);
    chk("wrap_fw", write_data[31:0], 32'd0);
    chk("wrap_fr", write_data[63:32], 32'd3);
    tick(10);

    // afu_en dropped while a request is pending
    grant_en = 1'b0;
    err(8'h77);
    wait_req("drop_req", 10);
    afu_en = 1'b0;
    tick(1);
    afu_en = 1'b1;
    chk("drop_req_low", write_request, 1'b0);
    chk("drop_busy_low", busy, 1'b0);
    chk("drop_data", write_data, '0);
    chk("drop_addr", write_addr, 32'd0);
    grant_en = 1'b1;
    err(8'h78);
    wait_req("post_drop_req", 10);
    chk("post_drop_line", write_data, mk_line(32'd0, 32'd0, 8'h78, 1'b1, 32'd0));
    tick(10);

    // Randomised traffic
    noise_en = 1'b1; grant_pct = 50;
    for (int seg = 0; seg < 4; seg++) begin
      int sel;
      sel = $urandom_range(0, 3);
      afu_en = 1'b0;
      update_period = (sel == 0) ? 16'd0 : (sel == 1) ? 16'd1 : 16'($urandom_range(2, 20));
      tick(1);
      for (int i = 0; i < 500; i++) begin
        afu_en            = ($urandom_range(0, 199) != 0);
        frame_written_inc = ($urandom_range(0, 2) == 0);
        frame_read_inc    = ($urandom_range(0, 2) == 0);
        error_pulse       = ($urandom_range(0, 24) == 0);
        error_code        = 8'($urandom);
        if ($urandom_range(0, 15) == 0) status_base_addr = $urandom;
        tick(1);
      end
    end
    frame_written_inc = 1'b0; frame_read_inc = 1'b0; error_pulse = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cci_status_writer.md
Name: cci_status_writer

Overview:
- Upstream producer for the status-write input of the CCI write arbiter.
- Maintains AFU progress counters: frames written, frames read, last error, and a sequence number.
- Snapshots the counters into one 512-bit cache line and requests a single write to a fixed host status address, either periodically or on error.
- Holds one write outstanding at a time and waits for the matching write response before issuing the next.

Parameters:
- MDATA_W, 14, width of the write mdata tag.
- STATUS_TAG, 2'b11, value placed in the top 2 mdata bits to mark status writes.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- afu_en  in  1  AFU enable; low acts as a synchronous clear of all state.
- status_base_addr  in  32  cache-line address of the status line; sampled at snapshot.
- update_period  in  16  cycles between periodic writes; 0 disables periodic writes.
- frame_written_inc  in  1  pulse; increments the frames-written counter.
- frame_read_inc  in  1  pulse; increments the frames-read counter.
- error_pulse  in  1  error event; forces a status write.
- error_code  in  8  error code, valid with error_pulse.
- write_request  out  1  status write request to the arbiter.
- write_addr  out  32  line address of the request.
- write_mdata  out  MDATA_W  request tag: {STATUS_TAG, seq[11:0]}.
- write_data  out  512  status line payload.
- write_grant  in  1  arbiter grant; transfer occurs when write_request && write_grant.
- write_resp_valid  in  1  write response valid from the rx channel.
- write_resp_mdata  in  MDATA_W  tag of the write response.
- busy  out  1  high in REQ or WAIT_RESP.

Behaviour:
- Reset, or afu_en==0, clears all state on the next edge:
  - all counters and seq become 0;
  - FSM goes to IDLE;
  - pending becomes 0 and the timer reloads;
  - write_request, write_addr, write_mdata, write_data and busy become 0.
- Counters:
  - fw_cnt and fr_cnt are 32 bits and increment by 1 per pulse; both may increment in the same cycle.
  - Counters wrap 0xFFFFFFFF to 0 silently.
  - Counters keep counting in every FSM state.
- Error: on error_pulse, err_code <= error_code and err_sticky <= 1, and pending is set. On repeated errors the last one wins.
- Timer:
  - 16-bit down-counter, active only when update_period != 0.
  - Loads update_period on reset, on a reload, or when update_period was 0.
  - Decrements every cycle. When it equals 1, it sets pending and reloads on the next cycle, giving exactly one trigger per update_period cycles.
  - update_period == 1 triggers every cycle; triggers coalesce into pending.
- Payload layout, captured at snapshot:
  - [31:0] fw_cnt; [63:32] fr_cnt; [71:64] err_code; [72] err_sticky; [95:73] 0;
  - [127:96] seq; [511:128] 0.
  - Snapshot values are the counter register values before any same-cycle increment.
- FSM:
  - IDLE: if pending, snapshot payload, write_addr and write_mdata; pending <= 0 (unless a new trigger arrives in the same cycle, which keeps it set). Go to REQ with write_request=1 on the next cycle. Minimum latency from trigger to write_request is 2 cycles.
  - REQ: write_request held at 1. Payload, address and mdata are stable until grant. On write_grant: write_request <= 0, seq <= seq+1 (32-bit wrap), go to WAIT_RESP.
  - WAIT_RESP: on write_resp_valid && write_resp_mdata == the issued mdata, go to IDLE. Non-matching responses are ignored. There is no timeout.
- Triggers arriving in REQ or WAIT_RESP set pending; they are serviced from IDLE with a fresh snapshot.
- write_grant outside REQ is ignored.
- err_sticky clears only on reset or when afu_en is low.
- A response that arrives after an afu_en clear is ignored by IDLE.
- busy is 1 exactly in REQ and WAIT_RESP.

Test Plan:
- Reset, then update_period=0 with no events for 100 cycles -> write_request stays 0, busy=0, all outputs 0.
- update_period=10, grant same cycle as request, response 3 cycles later -> one request every 10 cycles; data[127:96] = 0, 1, 2…; mdata = {2'b11, seq[11:0]}.
- 5 frame_written_inc pulses and 3 frame_read_inc pulses (2 simultaneous), then error_pulse with code 0x5A -> data[31:0]=5, [63:32]=3, [71:64]=0x5A, [72]=1.
- Hold grant low 20 cycles while counters change -> write_request stays 1 and write_data is unchanged; after grant, the next write carries the updated counts.
- In WAIT_RESP, a response with wrong mdata, then 2 errors, then the matching response -> FSM stays in WAIT_RESP on the wrong tag; exactly one further write follows, carrying the second error's code.
- Preload fw_cnt to 0xFFFFFFFF and pulse once -> 0. Drop afu_en in REQ -> next cycle write_request=0, busy=0, counters 0.
